demux3_router: RTL and testbench
================================

// Module: demux3_router
// PURPOSE
//  Inverse of the team's 3-to-1 select mux: steers one input stream to one of three outputs.
//  The destination is chosen per beat by the 2-bit code in_sel: 01->out1, 10->out2, 11->out3.
//  Code 00 means no destination: the beat is accepted, dropped and counted.
//  Each output has a one-entry registered slot with valid/ready handshake.
//  Sits between a single producer and three independent consumers.
// PARAMETERS
//  WIDTH  8  data width of input and each output
//  CNT_W  8  width of the saturating drop counter
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      input beat present
//  in_ready   out  1      router accepts the beat this cycle
//  in_data    in   WIDTH  input payload
//  in_sel     in   2      destination code (00 none, 01/10/11 -> out1/out2/out3)
//  outN_valid out  1      N=1..3; slot N holds a beat
//  outN_ready in   1      N=1..3; consumer N takes the beat
//  outN_data  out  WIDTH  N=1..3; slot N payload
//  drop_cnt   out  CNT_W  number of beats accepted with in_sel=00
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All outN_valid=0, outN_data=0, drop_cnt=0 immediately, without waiting for a clock edge.
//   - in_ready=0 while rst_n=0.
//   - Beats held in slots at reset are lost.
//  Handshake
//   - An input transfer happens on a rising edge when in_valid & in_ready.
//   - An output transfer happens when outN_valid & outN_ready.
//   - in_sel and in_data are sampled only on an input transfer.
//  Slot FSM (one per output)
//   - States: EMPTY, FULL. outN_valid = (state==FULL).
//   - EMPTY -> FULL when a transfer targets slot N.
//   - FULL -> EMPTY when drained and not loaded in the same cycle.
//   - FULL -> FULL when drained and loaded in the same cycle; the new data replaces the old,
//     giving full throughput of one beat per clock.
//   - FULL -> FULL when not drained; outN_data is held stable.
//  in_ready (combinational)
//   - in_sel=00: 1.
//   - Otherwise: target slot EMPTY, or target slot FULL and outN_ready=1.
//   - in_ready depends combinationally on outN_ready; the consumer must not gate ready on in_ready.
//  Latency and ordering
//   - Latency is 1 cycle: a beat accepted at edge k has outN_valid=1 after edge k.
//   - Order is preserved per destination. There is no ordering guarantee across destinations.
//  Independence
//   - A blocked slot stalls only beats addressed to it; other destinations are unaffected.
//  Drop path
//   - in_sel=00 transfer: drop_cnt += 1, saturating at 2^CNT_W-1 (no wrap).
//   - No slot changes state.
//  Boundary conditions
//   - in_valid=0: no slot loads; draining still proceeds.
//   - in_sel changing while in_valid=1 and in_ready=0 is legal; the new code re-evaluates in_ready.
//   - An X on in_sel while in_valid=0 must not corrupt state.
// STRUCTURE
//  Shared package demux_pkg:
//   - Constants SEL_NONE=2'b00, SEL_1=2'b01, SEL_2=2'b10, SEL_3=2'b11.
//   - Slot state encoding SLOT_EMPTY/SLOT_FULL.
//  Sub-module demux_slot, instantiated 3x:
//   - Ports: clk, rst_n, load, load_data, valid, ready, data, can_load.
//   - Contains the EMPTY/FULL FSM and data register.
//  Top level holds: the in_sel decode, the in_ready mux and the saturating drop counter.
// TESTING
//  1. Hold rst_n=0 with in_valid=1, in_sel=01.
//     -> in_ready=0, all outN_valid=0, drop_cnt=0.
//     Release reset -> in_ready=1.
//  2. in_sel=01, in_data=8'hA5, out1_ready=1.
//     -> after 1 edge: out1_valid=1, out1_data=8'hA5; out2_valid=out3_valid=0.
//  3. out2_ready=0; send 8'h11 then 8'h22 with sel=10.
//     -> 8'h22 stalls (in_ready=0) and out2_data stays 8'h11.
//     Raise out2_ready -> 8'h11 drained and 8'h22 loaded on the same edge.
//  4. Slot 2 blocked as in test 3; send sel=11, in_data=8'h33.
//     -> in_ready=1, out3_valid=1, out3_data=8'h33 next cycle; slot 2 unchanged.
//  5. 260 back-to-back beats with sel=00 (CNT_W=8).
//     -> drop_cnt=255 (saturated); no outN_valid ever asserted.
//  6. All three slots FULL; pulse rst_n low between clock edges.
//     -> all outN_valid drop to 0 immediately, before the next edge;
//        normal traffic resumes after release.

Source files
------------

// File: rtl/demux3_router_pkg.sv
// demux3_router shared types: destination codes and slot state.
// Imported by the slot, the top and the bench.
package demux_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_1    = 2'b01;
  localparam logic [1:0] SEL_2    = 2'b10;
  localparam logic [1:0] SEL_3    = 2'b11;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux3_router_if.sv
// demux3_router bus: one input stream, three output streams, drop count.
// master = producer/consumers side, slave = router side.
interface demux3_router_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out2_valid;
  logic             out2_ready;
  logic [WIDTH-1:0] out2_data;
  logic             out3_valid;
  logic             out3_ready;
  logic [WIDTH-1:0] out3_data;

  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output in_valid, in_data, in_sel,
    output out1_ready, out2_ready, out3_ready,
    input  in_ready,
    input  out1_valid, out1_data,
    input  out2_valid, out2_data,
    input  out3_valid, out3_data,
    input  drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel,
    input  out1_ready, out2_ready, out3_ready,
    output in_ready,
    output out1_valid, out1_data,
    output out2_valid, out2_data,
    output out3_valid, out3_data,
    output drop_cnt
  );
endinterface

// File: rtl/demux3_router_slot.sv
// demux_slot: one-entry registered output slot, EMPTY/FULL FSM.
// Ports: load/load_data in, valid/ready/data out handshake, can_load.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             can_load
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (load) begin
          state_d = SLOT_FULL;
          data_d  = load_data;
        end
      end
      SLOT_FULL: begin
        // a load is only issued when can_load, i.e. while draining
        if (load) begin
          data_d = load_data;
        end else if (ready) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid    = (state_q == SLOT_FULL);
  assign data     = data_q;
  // a full slot accepts a new beat on the edge it drains
  assign can_load = (state_q == SLOT_EMPTY) | ready;

endmodule

// File: rtl/demux3_router.sv
// demux3_router: steers one stream to one of three slots by in_sel.
// Ports: clk, rst_n, bus (slave); code 00 beats are dropped and counted.
module demux3_router
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  demux3_router_if.slave  bus
);

  logic [2:0]       can_load;
  logic [2:0]       load;
  logic             sel_rdy;
  logic             xfer;
  logic             drop;
  logic [CNT_W-1:0] drop_q, drop_d;

  always_comb begin
    sel_rdy = 1'b0;
    case (bus.in_sel)
      SEL_NONE: sel_rdy = 1'b1;
      SEL_1:    sel_rdy = can_load[0];
      SEL_2:    sel_rdy = can_load[1];
      SEL_3:    sel_rdy = can_load[2];
      default:  sel_rdy = 1'b0;
    endcase
  end

  assign xfer = bus.in_valid & sel_rdy & rst_n;

  // in_sel is only decoded under xfer so an idle X cannot load
  always_comb begin
    load = '0;
    drop = 1'b0;
    if (xfer) begin
      unique case (bus.in_sel)
        SEL_NONE: drop    = 1'b1;
        SEL_1:    load[0] = 1'b1;
        SEL_2:    load[1] = 1'b1;
        SEL_3:    load[2] = 1'b1;
        default:  drop    = 1'b0;
      endcase
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign bus.in_ready = rst_n & sel_rdy;
  assign bus.drop_cnt = drop_q;

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load[0]),
    .load_data (bus.in_data),
    .valid     (bus.out1_valid),
    .ready     (bus.out1_ready),
    .data      (bus.out1_data),
    .can_load  (can_load[0])
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load[1]),
    .load_data (bus.in_data),
    .valid     (bus.out2_valid),
    .ready     (bus.out2_ready),
    .data      (bus.out2_data),
    .can_load  (can_load[1])
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load[2]),
    .load_data (bus.in_data),
    .valid     (bus.out3_valid),
    .ready     (bus.out3_ready),
    .data      (bus.out3_data),
    .can_load  (can_load[2])
  );

endmodule

// File: tb/tb_demux3_router.sv
// tb_demux3_router: scoreboard bench for demux3_router.
// Per-slot queues hold the expected beat; a negedge monitor checks.
module tb_demux3_router;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   drop_m = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];

  demux3_router_if #(.WIDTH(8), .CNT_W(8)) bus ();

  demux3_router #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mon_slot(input string tag, ref logic [7:0] q[$],
                          input logic v, input logic [7:0] d,
                          input logic r);
    chk({tag, "_valid"}, 32'(v), 32'(q.size() != 0));
    if (v && q.size() != 0) begin
      chk({tag, "_data"}, 32'(d), 32'(q[0]));
    end
    if (v && r && q.size() != 0) begin
      void'(q.pop_front());
    end
  endtask

  always @(negedge rst_n) begin
    q1.delete();
    q2.delete();
    q3.delete();
    drop_m = 0;
  end

  always @(negedge clk) begin
    logic exp_rdy;
    if (!rst_n) begin
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_valid", {29'd0, bus.out1_valid, bus.out2_valid,
                        bus.out3_valid}, 32'd0);
      chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
    end else begin
      chk("drop_cnt", 32'(bus.drop_cnt), 32'(drop_m));
      case (bus.in_sel)
        SEL_1:   exp_rdy = (q1.size() == 0) | bus.out1_ready;
        SEL_2:   exp_rdy = (q2.size() == 0) | bus.out2_ready;
        SEL_3:   exp_rdy = (q3.size() == 0) | bus.out3_ready;
        default: exp_rdy = 1'b1;
      endcase
      if (bus.in_valid) begin
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      end
      mon_slot("out1", q1, bus.out1_valid, bus.out1_data, bus.out1_ready);
      mon_slot("out2", q2, bus.out2_valid, bus.out2_data, bus.out2_ready);
      mon_slot("out3", q3, bus.out3_valid, bus.out3_data, bus.out3_ready);
      if (bus.in_valid && exp_rdy) begin
        case (bus.in_sel)
          SEL_1:   q1.push_back(bus.in_data);
          SEL_2:   q2.push_back(bus.in_data);
          SEL_3:   q3.push_back(bus.in_data);
          default: if (drop_m < 255) drop_m++;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic readies(input logic r1, input logic r2, input logic r3);
    bus.out1_ready = r1;
    bus.out2_ready = r2;
    bus.out3_ready = r3;
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.in_sel   = SEL_1;
    bus.in_data  = 8'hA5;
    readies(1'b1, 1'b1, 1'b1);

    // reset held with a pending beat
    repeat (3) step();
    chk("t1_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t1_out1_valid", 32'(bus.out1_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t1_ready_rel", 32'(bus.in_ready), 32'd1);

    // first beat lands in slot 1 after one edge
    step();
    bus.in_valid = 1'b0;
    chk("t2_out1_valid", 32'(bus.out1_valid), 32'd1);
    chk("t2_out1_data", 32'(bus.out1_data), 32'hA5);
    chk("t2_others", {30'd0, bus.out2_valid, bus.out3_valid}, 32'd0);
    step();

    // slot 2 blocked, second beat stalls
    readies(1'b1, 1'b0, 1'b0);
    send(SEL_2, 8'h11);
    bus.in_valid = 1'b1;
    bus.in_sel   = SEL_2;
    bus.in_data  = 8'h22;
    repeat (3) @(negedge clk);
    chk("t3_stall", 32'(bus.in_ready), 32'd0);
    chk("t3_hold", 32'(bus.out2_data), 32'h11);
    step();
    bus.out2_ready = 1'b1;
    @(negedge clk);
    chk("t3_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.out2_ready = 1'b0;
    @(negedge clk);
    chk("t3_new_data", 32'(bus.out2_data), 32'h22);

    // slot 2 still blocked; slot 3 unaffected
    step();
    bus.in_valid = 1'b1;
    bus.in_sel   = SEL_3;
    bus.in_data  = 8'h33;
    #1;
    chk("t4_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("t4_out3_data", 32'(bus.out3_data), 32'h33);
    chk("t4_out2_data", 32'(bus.out2_data), 32'h22);
    readies(1'b1, 1'b1, 1'b1);
    repeat (2) step();

    // drop counter saturation
    bus.in_valid = 1'b1;
    bus.in_sel   = SEL_NONE;
    repeat (260) step();
    bus.in_valid = 1'b0;
    step();
    chk("t5_drop_sat", 32'(bus.drop_cnt), 32'd255);

    // async reset with all slots full
    readies(1'b0, 1'b0, 1'b0);
    send(SEL_1, 8'h01);
    send(SEL_2, 8'h02);
    send(SEL_3, 8'h03);
    chk("t6_full", {29'd0, bus.out1_valid, bus.out2_valid,
                    bus.out3_valid}, 32'h7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async", {29'd0, bus.out1_valid, bus.out2_valid,
                     bus.out3_valid}, 32'h0);
    chk("t6_drop", 32'(bus.drop_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
    readies(1'b1, 1'b1, 1'b1);
    send(SEL_1, 8'h5A);
    chk("t6_resume", 32'(bus.out1_data), 32'h5A);

    // random traffic, X-free idle sel changes included
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_sel   = 2'($urandom_range(0, 3));
      bus.in_data  = 8'($urandom);
      bus.out1_ready = 1'($urandom_range(0, 1));
      bus.out2_ready = 1'($urandom_range(0, 1));
      bus.out3_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.in_valid = 1'b0;
    readies(1'b1, 1'b1, 1'b1);
    repeat (3) step();
    chk("drain_empty", {29'd0, bus.out1_valid, bus.out2_valid,
                        bus.out3_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
